// File: rtl/wb_arbiter2_if.sv
// wb_arbiter2_if: Wishbone bus bundle between two masters, the arbiter and one slave
interface wb_arbiter2_if;
  logic [63:0] m0adr_i, m1adr_i, sadr_o;
  logic [15:0] m0dat_i, m1dat_i, m0dat_o, m1dat_o, sdat_o, sdat_i;
  logic [1:0] m0sel_i, m1sel_i, ssel_o, gnt_o;
  logic m0we_i, m0stb_i, m0cyc_i, m0ack_o, m0err_o;
  logic m1we_i, m1stb_i, m1cyc_i, m1ack_o, m1err_o;
  logic swe_o, sstb_o, scyc_o, sack_i;
  modport slave (
    input m0adr_i, m0dat_i, m0we_i, m0sel_i, m0stb_i, m0cyc_i,
    input m1adr_i, m1dat_i, m1we_i, m1sel_i, m1stb_i, m1cyc_i,
    input sack_i, sdat_i,
    output m0ack_o, m0err_o, m0dat_o, m1ack_o, m1err_o, m1dat_o,
    output sadr_o, sdat_o, swe_o, ssel_o, sstb_o, scyc_o, gnt_o
  );
  modport master (
    output m0adr_i, m0dat_i, m0we_i, m0sel_i, m0stb_i, m0cyc_i,
    output m1adr_i, m1dat_i, m1we_i, m1sel_i, m1stb_i, m1cyc_i,
    output sack_i, sdat_i,
    input m0ack_o, m0err_o, m0dat_o, m1ack_o, m1err_o, m1dat_o,
    input sadr_o, sdat_o, swe_o, ssel_o, sstb_o, scyc_o, gnt_o
  );
endinterface

// File: rtl/wb_arbiter2.sv
// wb_arbiter2: two-master Wishbone arbiter with CYC-framed round-robin grant and ACK watchdog
module wb_arbiter2 #(
  parameter int TIMEOUT = 255,
  parameter int CNTW = 16
) (
  input logic clk_i,
  input logic reset_i,
  wb_arbiter2_if.slave bus
);
  typedef enum logic [1:0] {IDLE, G0, G1} state_t;
  state_t r_state, w_next;
  logic r_last, r_err0, r_err1;
  logic [CNTW-1:0] r_cnt;
  logic w_g0, w_g1, w_stb, w_hold, w_hit;
  always_comb begin
    w_g0 = r_state == G0;
    w_g1 = r_state == G1;
    w_next = w_g0 ? (bus.m0cyc_i ? G0 : bus.m1cyc_i ? G1 : IDLE)
           : w_g1 ? (bus.m1cyc_i ? G1 : bus.m0cyc_i ? G0 : IDLE)
           : (bus.m0cyc_i && bus.m1cyc_i) ? (r_last ? G0 : G1)
           : bus.m0cyc_i ? G0 : bus.m1cyc_i ? G1 : IDLE;
    bus.sadr_o = w_g0 ? bus.m0adr_i : w_g1 ? bus.m1adr_i : '0;
    bus.sdat_o = w_g0 ? bus.m0dat_i : w_g1 ? bus.m1dat_i : '0;
    bus.swe_o = w_g0 ? bus.m0we_i : w_g1 && bus.m1we_i;
    bus.ssel_o = w_g0 ? bus.m0sel_i : w_g1 ? bus.m1sel_i : '0;
    bus.sstb_o = w_g0 ? bus.m0stb_i : w_g1 && bus.m1stb_i;
    bus.scyc_o = w_g0 ? bus.m0cyc_i : w_g1 && bus.m1cyc_i;
    bus.gnt_o = {w_g1, w_g0};
    bus.m0ack_o = w_g0 && bus.sack_i;
    bus.m1ack_o = w_g1 && bus.sack_i;
    bus.m0dat_o = bus.sdat_i;
    bus.m1dat_o = bus.sdat_i;
    bus.m0err_o = r_err0;
    bus.m1err_o = r_err1;
    w_stb = bus.sstb_o;
    // a stall only counts while the grant is kept; leaving Gn clears the watchdog
    w_hold = (w_g0 || w_g1) && w_next == r_state && w_stb && !bus.sack_i;
    w_hit = w_hold && r_cnt == CNTW'(TIMEOUT - 1);
  end
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      r_state <= IDLE;
      r_last <= 1'b1;
      r_cnt <= '0;
      r_err0 <= 1'b0;
      r_err1 <= 1'b0;
    end else begin
      r_state <= w_next;
      r_last <= w_g1 ? 1'b1 : w_g0 ? 1'b0 : r_last;
      r_cnt <= (w_hold && !w_hit) ? r_cnt + 1'b1 : '0;
      r_err0 <= w_hit && w_g0;
      r_err1 <= w_hit && w_g1;
    end
  end
endmodule

// File: tb/tb_wb_arbiter2.sv
// tb_wb_arbiter2: directed checks of grant, routing, cycle lock, watchdog and reset
module tb_wb_arbiter2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_vec = 0;
  int n_bad = 0;
  wb_arbiter2_if bus();
  wb_arbiter2 #(.TIMEOUT(8), .CNTW(16)) dut (.clk_i(clk), .reset_i(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic settle();
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    bus.m0adr_i = 64'h1000; bus.m0dat_i = '0; bus.m0we_i = 0; bus.m0sel_i = 2'b11;
    bus.m0stb_i = 1; bus.m0cyc_i = 1;
    bus.m1adr_i = 64'h2002; bus.m1dat_i = '0; bus.m1we_i = 0; bus.m1sel_i = 2'b11;
    bus.m1stb_i = 1; bus.m1cyc_i = 1;
    bus.sack_i = 0; bus.sdat_i = '0;
    tick(); tick(); tick();
    chk("rst_gnt", 64'(bus.gnt_o), 0);
    chk("rst_scyc", 64'(bus.scyc_o), 0);
    chk("rst_sstb", 64'(bus.sstb_o), 0);
    chk("rst_sadr", bus.sadr_o, 0);
    chk("rst_ack", 64'({bus.m0ack_o, bus.m1ack_o}), 0);
    chk("rst_err", 64'({bus.m0err_o, bus.m1err_o}), 0);
    rst_n = 1;
    tick();
    chk("first_gnt", 64'(bus.gnt_o), 64'b01);
    chk("first_sadr", bus.sadr_o, 64'h1000);
    chk("first_scyc", 64'(bus.scyc_o), 1);
    bus.m0cyc_i = 0; bus.m0stb_i = 0; bus.m1cyc_i = 0; bus.m1stb_i = 0;
    tick();
    chk("idle_gnt", 64'(bus.gnt_o), 0);
    chk("idle_scyc", 64'(bus.scyc_o), 0);
    // single-master read from fetch
    bus.m1cyc_i = 1; bus.m1stb_i = 1; bus.m1adr_i = 64'h2002;
    settle();
    chk("rd_latency_scyc", 64'(bus.scyc_o), 0);
    tick();
    chk("rd_gnt", 64'(bus.gnt_o), 64'b10);
    chk("rd_sadr", bus.sadr_o, 64'h2002);
    chk("rd_sstb", 64'(bus.sstb_o), 1);
    chk("rd_ack_wait", 64'(bus.m1ack_o), 0);
    tick();
    chk("rd_ack_wait2", 64'(bus.m1ack_o), 0);
    tick();
    bus.sack_i = 1; bus.sdat_i = 16'hBEEF;
    settle();
    chk("rd_m1ack", 64'(bus.m1ack_o), 1);
    chk("rd_m1dat", 64'(bus.m1dat_o), 64'hBEEF);
    chk("rd_m0ack", 64'(bus.m0ack_o), 0);
    chk("rd_m0dat_bcast", 64'(bus.m0dat_o), 64'hBEEF);
    tick();
    bus.sack_i = 0; bus.m1cyc_i = 0; bus.m1stb_i = 0;
    settle();
    chk("rd_m1ack_end", 64'(bus.m1ack_o), 0);
    tick();
    chk("rd_idle", 64'(bus.gnt_o), 0);
    // tie after fetch served: LSU wins, then hands over with no idle bubble
    bus.m0cyc_i = 1; bus.m0stb_i = 1; bus.m0adr_i = 64'h3000;
    bus.m1cyc_i = 1; bus.m1stb_i = 1; bus.m1adr_i = 64'h4000;
    tick();
    chk("rr_gnt0", 64'(bus.gnt_o), 64'b01);
    chk("rr_sadr0", bus.sadr_o, 64'h3000);
    bus.sack_i = 1;
    settle();
    chk("rr_m0ack", 64'(bus.m0ack_o), 1);
    chk("rr_m1ack", 64'(bus.m1ack_o), 0);
    tick();
    bus.sack_i = 0; bus.m0cyc_i = 0; bus.m0stb_i = 0;
    settle();
    chk("rr_rel_gnt", 64'(bus.gnt_o), 64'b01);
    tick();
    chk("rr_handover_gnt", 64'(bus.gnt_o), 64'b10);
    chk("rr_handover_sadr", bus.sadr_o, 64'h4000);
    chk("rr_handover_scyc", 64'(bus.scyc_o), 1);
    bus.m1cyc_i = 0; bus.m1stb_i = 0;
    tick();
    chk("rr_idle", 64'(bus.gnt_o), 0);
    bus.m0cyc_i = 1; bus.m0stb_i = 1; bus.m1cyc_i = 1; bus.m1stb_i = 1;
    tick();
    chk("rr_tie_lsu", 64'(bus.gnt_o), 64'b01);
    bus.m0cyc_i = 0; bus.m0stb_i = 0; bus.m1cyc_i = 0; bus.m1stb_i = 0;
    tick();
    bus.m0cyc_i = 1; bus.m0stb_i = 1; bus.m1cyc_i = 1; bus.m1stb_i = 1;
    tick();
    chk("rr_tie_fetch", 64'(bus.gnt_o), 64'b10);
    bus.m0cyc_i = 0; bus.m0stb_i = 0; bus.m1cyc_i = 0; bus.m1stb_i = 0;
    tick();
    // 4-beat LSU write locks out a requesting fetch
    bus.m0cyc_i = 1; bus.m0stb_i = 0; bus.m0we_i = 1;
    bus.m1cyc_i = 1; bus.m1stb_i = 1; bus.m1adr_i = 64'h5000;
    tick();
    chk("lock_gnt", 64'(bus.gnt_o), 64'b01);
    for (int i = 0; i < 4; i++) begin
      bus.m0adr_i = 64'h100 + 64'(2 * i);
      bus.m0dat_i = 16'(16'h1111 * (i + 1));
      bus.m0stb_i = 1; bus.sack_i = 1;
      settle();
      chk("lock_sadr", bus.sadr_o, 64'h100 + 64'(2 * i));
      chk("lock_sdat", 64'(bus.sdat_o), 64'(16'h1111 * (i + 1)));
      chk("lock_swe", 64'(bus.swe_o), 1);
      chk("lock_gnt_beat", 64'(bus.gnt_o), 64'b01);
      chk("lock_m0ack", 64'(bus.m0ack_o), 1);
      tick();
    end
    bus.m0cyc_i = 0; bus.m0stb_i = 0; bus.m0we_i = 0; bus.sack_i = 0;
    tick();
    chk("lock_fetch_gnt", 64'(bus.gnt_o), 64'b10);
    chk("lock_fetch_sadr", bus.sadr_o, 64'h5000);
    bus.m1cyc_i = 0; bus.m1stb_i = 0;
    tick();
    // watchdog: eight stalled clocks raise a one-clock error
    bus.m0cyc_i = 1; bus.m0stb_i = 1; bus.m0adr_i = 64'h6000;
    tick();
    for (int k = 1; k <= 8; k++) begin
      chk("wd_err_early", 64'(bus.m0err_o), 0);
      tick();
    end
    chk("wd_err_pulse", 64'(bus.m0err_o), 1);
    chk("wd_m1err", 64'(bus.m1err_o), 0);
    chk("wd_gnt", 64'(bus.gnt_o), 64'b01);
    tick();
    chk("wd_err_one_clk", 64'(bus.m0err_o), 0);
    chk("wd_gnt_kept", 64'(bus.gnt_o), 64'b01);
    bus.m0stb_i = 0;
    tick();
    bus.m0stb_i = 1;
    for (int k = 1; k <= 7; k++) tick();
    bus.sack_i = 1;
    settle();
    chk("wd_ack_wins_ack", 64'(bus.m0ack_o), 1);
    tick();
    bus.sack_i = 0;
    settle();
    chk("wd_ack_wins_err", 64'(bus.m0err_o), 0);
    bus.m0cyc_i = 0; bus.m0stb_i = 0;
    tick();
    // reset in the middle of a fetch transfer
    bus.m1cyc_i = 1; bus.m1stb_i = 1;
    tick();
    chk("mrst_pre_gnt", 64'(bus.gnt_o), 64'b10);
    tick();
    rst_n = 0;
    tick();
    chk("mrst_scyc", 64'(bus.scyc_o), 0);
    chk("mrst_sstb", 64'(bus.sstb_o), 0);
    chk("mrst_gnt", 64'(bus.gnt_o), 0);
    chk("mrst_m1err", 64'(bus.m1err_o), 0);
    rst_n = 1;
    tick();
    chk("mrst_regrant", 64'(bus.gnt_o), 64'b10);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/wb_arbiter2.md
Name: wb_arbiter2

Overview:
- Two-master to one-slave Wishbone B.4 arbiter for the 16-bit, 64-bit-address CPU bus.
- Master 0 is the load/store unit; master 1 is the instruction fetch unit.
- Grants the shared bus per whole cycle (CYC framed), with round-robin tie-breaking and no cycle interleaving.
- A stall watchdog flags a slave that never acknowledges.

Parameters:
TIMEOUT, 255, cycles a granted STB may wait for ACK before the error pulse (1..65535).
CNTW, 16, watchdog counter width; must hold TIMEOUT.

Ports:
clk_i  in  1  clock, rising edge
reset_i  in  1  synchronous reset, active-low (asserted when 0)
m0adr_i  in  64  LSU address
m0dat_i  in  16  LSU write data
m0we_i  in  1  LSU write enable
m0sel_i  in  2  LSU byte lanes
m0stb_i  in  1  LSU strobe
m0cyc_i  in  1  LSU cycle
m0ack_o  out  1  ACK routed to LSU
m0err_o  out  1  watchdog error to LSU
m0dat_o  out  16  read data to LSU
m1adr_i/m1dat_i/m1we_i/m1sel_i/m1stb_i/m1cyc_i  in  64/16/1/2/1/1  fetch-side equivalents
m1ack_o  out  1  ACK routed to fetch
m1err_o  out  1  watchdog error to fetch
m1dat_o  out  16  read data to fetch
sadr_o  out  64  slave address
sdat_o  out  16  slave write data
swe_o  out  1  slave write enable
ssel_o  out  2  slave byte lanes
sstb_o  out  1  slave strobe
scyc_o  out  1  slave cycle
sack_i  in  1  slave acknowledge
sdat_i  in  16  slave read data
gnt_o  out  2  one-hot current grant (bit0 = LSU, bit1 = fetch); 00 when idle

Behaviour:
- States: IDLE, G0, G1. Registered. gnt_o decodes the state.
- Reset (reset_i==0 at clk edge):
  - State goes to IDLE; the last-served flag goes to 1, so the LSU wins the first tie.
  - Watchdog counter and both err outputs clear.
  - All slave outputs are 0, both ack/err outputs are 0, and gnt_o is 00.
  - Reset mid-cycle abandons the transaction immediately; there is no draining.
- IDLE:
  - Only m0cyc_i set: go to G0. Only m1cyc_i set: go to G1.
  - Both set: grant the master not served last.
  - Neither set: stay in IDLE.
  - Arbitration latency is one clock: the slave sees CYC the cycle after the master raises it.
- G0 / G1:
  - Slave adr/dat/we/sel/stb/cyc combinationally mirror the granted master.
  - sack_i is routed only to the granted master's ack; the other master's ack stays 0.
  - sdat_i is broadcast to both mNdat_o; the masters qualify it with their own ack.
  - On each clock in Gn, the last-served flag is set to n.
- Release: when the granted master drops cyc:
  - If the other master's cyc is high, go directly to its grant state (no idle bubble).
  - Otherwise go to IDLE.
  - In the release clock the slave outputs already follow the new state after the edge.
  - scyc_o is low for that cycle only if the next state is IDLE.
- A master that holds cyc keeps the bus indefinitely: this is a cycle lock, with no preemption. Multi-beat LSU transfers stay atomic.
- Watchdog:
  - The counter increments each clock when state is Gn, the granted stb is 1 and sack_i is 0.
  - It clears on sack_i, on stb low, on leaving Gn, and on reset.
  - When the counter equals TIMEOUT-1 and sack_i is 0, the granted mNerr_o pulses high for exactly one clock (registered) and the counter clears.
  - The grant is unchanged; the master must drop cyc to release the bus.
  - sack_i arriving in the same cycle as the threshold wins: ACK is forwarded and no error is raised.
- Simultaneous events:
  - The granted master dropping cyc while sack_i is high: the ack is still forwarded that cycle.
  - The non-granted master's stb/cyc never affects the slave outputs.

Test Plan:
- Reset: hold reset_i=0 three clocks while both cyc=1, then release → cycle 1 after release gnt_o=01; sadr_o mirrors m0adr_i=0x1000.
- Single-master read: m1cyc/stb=1, adr=0x2002, slave acks two clocks later with sdat_i=0xBEEF → m1ack_o=1 for one clock, m1dat_o=0xBEEF, m0ack_o=0 throughout.
- Round-robin ties:
  - Both request; LSU is granted, completes and drops cyc while fetch still requests → gnt_o goes 01→10 with no IDLE cycle.
  - Both request again after fetch finishes → LSU is granted.
- Lock: LSU issues a 4-beat write (adr …0,2,4,6; dat 0x1111..0x4444) keeping cyc high while fetch requests → the slave sees exactly the four LSU beats in order; fetch is granted only after LSU drops cyc.
- Watchdog: TIMEOUT=8, LSU stb with no sack_i → m0err_o high exactly on the 8th stalled clock, one clock wide, gnt_o stays 01. Repeat with sack_i on the 8th clock → ack forwarded, err stays 0.
- Reset mid-transfer: assert reset_i=0 while in G1 with stb high → next clock scyc_o=0, sstb_o=0, gnt_o=00, m1err_o=0.
